// File: rtl/nco_sine_gen_if.sv
// Sample stream of nco_sine_gen: valid/ready handshake with sine and,
// when NCO_QUAD_OUT_EN is defined, the quadrature cosine sample.
interface nco_sine_gen_if #(
    parameter int OUT_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] sine_out;
`ifdef NCO_QUAD_OUT_EN
    logic [OUT_W-1:0] cos_out;

    modport master (output out_valid, output sine_out, output cos_out, input out_ready);
    modport slave  (input out_valid, input sine_out, input cos_out, output out_ready);
`else
    modport master (output out_valid, output sine_out, input out_ready);
    modport slave  (input out_valid, input sine_out, output out_ready);
`endif
endinterface

// File: rtl/nco_sine_gen.sv
// Phase-accumulator NCO with elaboration-time sine table and valid/ready output.
// NCO_QUAD_OUT_EN adds a quadrature cos_out read from the same table.
module nco_sine_gen #(
    parameter int                 PHASE_W   = 16,
    parameter int                 LUT_DEPTH = 32,
    parameter int                 OUT_W     = 8,
    parameter logic [PHASE_W-1:0] FCW_INIT  = PHASE_W'(16'h0800)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] fcw_in,
    input  logic               fcw_load,
    input  logic [PHASE_W-1:0] phase_ofs,
    input  logic               phase_clr,
    output logic               fcw_pending,
    nco_sine_gen_if.master     stream
);
    localparam int IDX_W = $clog2(LUT_DEPTH);
    localparam int MID   = 2 ** (OUT_W - 2);

    function automatic logic [OUT_W-1:0] lut_entry(input int k);
        real ang;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_DEPTH);
        return OUT_W'($rtoi(real'(MID) * (1.0 + $sin(ang)) + 0.5));
    endfunction

    logic [OUT_W-1:0] lut [LUT_DEPTH];
    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        assign lut[k] = lut_entry(k);
    end

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] fcw_active;
    logic [PHASE_W-1:0] pend_fcw;
    logic [PHASE_W-1:0] sum;
    logic               carry;
    logic               adv;
    logic               wrap;
    logic [IDX_W-1:0]   idx;
    logic               v1;

    assign adv          = !(stream.out_valid && !stream.out_ready);
    assign {carry, sum} = {1'b0, phase} + {1'b0, fcw_active};
    assign wrap         = en && adv && carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= '0;
            fcw_active  <= FCW_INIT;
            pend_fcw    <= '0;
            fcw_pending <= 1'b0;
        end else if (phase_clr) begin
            // Clear wins over increment; a same-cycle load is applied directly
            phase       <= '0;
            fcw_pending <= 1'b0;
            if (fcw_load) begin
                fcw_active <= fcw_in;
                pend_fcw   <= fcw_in;
            end else if (fcw_pending) begin
                fcw_active <= pend_fcw;
            end
        end else begin
            if (en && adv)
                phase <= sum;
            if (fcw_pending && (wrap || !en)) begin
                fcw_active  <= pend_fcw;
                fcw_pending <= 1'b0;
            end
            if (fcw_load) begin
                pend_fcw    <= fcw_in;
                fcw_pending <= 1'b1;
            end
        end
    end

`ifdef NCO_QUAD_OUT_EN
    logic [IDX_W-1:0] cos_idx;
    assign cos_idx = idx + IDX_W'(LUT_DEPTH / 4);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx               <= '0;
            v1                <= 1'b0;
            stream.out_valid  <= 1'b0;
            stream.sine_out   <= OUT_W'(MID);
`ifdef NCO_QUAD_OUT_EN
            stream.cos_out    <= OUT_W'(MID);
`endif
        end else if (adv) begin
            idx               <= IDX_W'((phase + phase_ofs) >> (PHASE_W - IDX_W));
            v1                <= en;
            stream.out_valid  <= v1;
            stream.sine_out   <= lut[idx];
`ifdef NCO_QUAD_OUT_EN
            stream.cos_out    <= lut[cos_idx];
`endif
        end
    end
endmodule

// File: tb/tb_nco_sine_gen.sv
// Directed bench for nco_sine_gen: default instance plus a 64-entry/10-bit/12-bit-phase instance.
module tb_nco_sine_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, fcw_load, phase_clr, fcw_pending;
    logic [15:0] fcw_in, phase_ofs;
    logic        rst1, en1, fcw_pending1;

    int total = 0;
    int bad   = 0;
    logic [15:0] vmax, vmin;

    logic [7:0] LUT [32] = '{
        8'h40, 8'h4c, 8'h58, 8'h64, 8'h6d, 8'h75, 8'h7b, 8'h7f,
        8'h80, 8'h7f, 8'h7b, 8'h75, 8'h6d, 8'h64, 8'h58, 8'h4c,
        8'h40, 8'h34, 8'h28, 8'h1c, 8'h13, 8'h0b, 8'h05, 8'h01,
        8'h00, 8'h01, 8'h05, 8'h0b, 8'h13, 8'h1c, 8'h28, 8'h34
    };

    nco_sine_gen_if #(.OUT_W(8))  s0 ();
    nco_sine_gen_if #(.OUT_W(10)) s1 ();

    nco_sine_gen dut (
        .clk(clk), .rst(rst), .en(en), .fcw_in(fcw_in), .fcw_load(fcw_load),
        .phase_ofs(phase_ofs), .phase_clr(phase_clr), .fcw_pending(fcw_pending),
        .stream(s0)
    );

    nco_sine_gen #(.PHASE_W(12), .LUT_DEPTH(64), .OUT_W(10), .FCW_INIT(12'h040)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .fcw_in(12'h000), .fcw_load(1'b0),
        .phase_ofs(12'h000), .phase_clr(1'b0), .fcw_pending(fcw_pending1),
        .stream(s1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; fcw_load = 1'b0; fcw_in = '0; phase_ofs = '0; phase_clr = 1'b0;
        s0.out_ready = 1'b1;
        rst1 = 1'b1; en1 = 1'b0; s1.out_ready = 1'b1;
        step(); step();
        chk("rst_sine", 16'(s0.sine_out), 16'h40);
        chk("rst_valid", 16'(s0.out_valid), 16'h0);
        chk("rst_pend", 16'(fcw_pending), 16'h0);
`ifdef NCO_QUAD_OUT_EN
        chk("rst_cos", 16'(s0.cos_out), 16'h40);
`endif
        chk("rst1_sine", 16'(s1.sine_out), 16'h100);
        chk("rst1_valid", 16'(s1.out_valid), 16'h0);
        chk("rst1_pend", 16'(fcw_pending1), 16'h0);

        rst = 1'b0; en = 1'b1;
        step();
        chk("latency", 16'(s0.out_valid), 16'h0);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("seq", 16'(s0.sine_out), 16'(LUT[i % 32]));
            chk("seq_valid", 16'(s0.out_valid), 16'h1);
`ifdef NCO_QUAD_OUT_EN
            chk("seq_cos", 16'(s0.cos_out), 16'(LUT[(i + 8) % 32]));
`endif
        end

        fcw_in = 16'h1000; fcw_load = 1'b1;
        step();
        fcw_load = 1'b0;
        chk("load_seq", 16'(s0.sine_out), 16'(LUT[8]));
        chk("load_pend", 16'(fcw_pending), 16'h1);
        for (int j = 0; j < 23; j++) begin
            step();
            chk("prewrap", 16'(s0.sine_out), 16'(LUT[9 + j]));
            chk("prewrap_pend", 16'(fcw_pending), (j < 21) ? 16'h1 : 16'h0);
        end
        for (int j = 0; j < 16; j++) begin
            step();
            chk("dblstep", 16'(s0.sine_out), 16'(LUT[(2 * j) % 32]));
        end

        s0.out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("stall_sine", 16'(s0.sine_out), 16'(LUT[30]));
            chk("stall_valid", 16'(s0.out_valid), 16'h1);
        end
        s0.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("resume", 16'(s0.sine_out), 16'(LUT[2 * j]));
        end

        phase_ofs = 16'h8000;
        step(); chk("ofs_lag", 16'(s0.sine_out), 16'(LUT[8]));
        step(); chk("ofs_a", 16'(s0.sine_out), 16'(LUT[26]));
        step(); chk("ofs_b", 16'(s0.sine_out), 16'(LUT[28]));
        phase_ofs = 16'h0000;
        step(); chk("ofs_off_lag", 16'(s0.sine_out), 16'(LUT[30]));
        step(); chk("ofs_off", 16'(s0.sine_out), 16'(LUT[16]));

        phase_clr = 1'b1; fcw_load = 1'b1; fcw_in = 16'h0400;
        step();
        phase_clr = 1'b0; fcw_load = 1'b0;
        chk("clr_flight0", 16'(s0.sine_out), 16'(LUT[18]));
        chk("clr_pend", 16'(fcw_pending), 16'h0);
        step(); chk("clr_flight1", 16'(s0.sine_out), 16'(LUT[20]));
        for (int j = 0; j < 8; j++) begin
            step();
            chk("halfstep", 16'(s0.sine_out), 16'(LUT[j / 2]));
        end

        en = 1'b0;
        step(); chk("drain1", 16'(s0.out_valid), 16'h1);
        step(); chk("drain2", 16'(s0.out_valid), 16'h0);
        fcw_in = 16'h0800; fcw_load = 1'b1;
        step();
        fcw_load = 1'b0;
        chk("idle_pend", 16'(fcw_pending), 16'h1);
        step(); chk("idle_apply", 16'(fcw_pending), 16'h0);
        en = 1'b1; phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        chk("restart_v0", 16'(s0.out_valid), 16'h0);
        step();
        chk("restart_v1", 16'(s0.out_valid), 16'h1);
        chk("restart_held", 16'(s0.sine_out), 16'(LUT[4]));
        for (int j = 0; j < 4; j++) begin
            step();
            chk("restart_seq", 16'(s0.sine_out), 16'(LUT[j]));
        end

        fcw_in = 16'h1000; fcw_load = 1'b1;
        step();
        fcw_load = 1'b0;
        chk("pre_rst_pend", 16'(fcw_pending), 16'h1);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 16'(s0.out_valid), 16'h0);
        chk("arst_sine", 16'(s0.sine_out), 16'h40);
        chk("arst_pend", 16'(fcw_pending), 16'h0);
        rst = 1'b0;
        step(); chk("rec_v0", 16'(s0.out_valid), 16'h0);
        step(); chk("rec_s0", 16'(s0.sine_out), 16'(LUT[0]));
        step(); chk("rec_s1", 16'(s0.sine_out), 16'(LUT[1]));
        chk("rec_pend", 16'(fcw_pending), 16'h0);

        rst1 = 1'b0; en1 = 1'b1;
        vmax = 16'h0000; vmin = 16'hffff;
        for (int j = 0; j < 70; j++) begin
            step();
            if (s1.out_valid) begin
                if (16'(s1.sine_out) > vmax) vmax = 16'(s1.sine_out);
                if (16'(s1.sine_out) < vmin) vmin = 16'(s1.sine_out);
            end
        end
        chk("p1_peak", vmax, 16'h200);
        chk("p1_min", vmin, 16'h000);
        #3 rst1 = 1'b1;
        #1;
        chk("p1_arst_sine", 16'(s1.sine_out), 16'h100);
        chk("p1_arst_valid", 16'(s1.out_valid), 16'h0);
        rst1 = 1'b0;
        step(); chk("p1_rec_v0", 16'(s1.out_valid), 16'h0);
        step();
        chk("p1_rec_v1", 16'(s1.out_valid), 16'h1);
        chk("p1_rec_s0", 16'(s1.sine_out), 16'h100);
`ifdef NCO_QUAD_OUT_EN
        chk("p1_cos0", 16'(s1.cos_out), 16'h200);
`endif
        step();
        chk("p1_rec_s1", 16'(s1.sine_out), 16'h119);
`ifdef NCO_QUAD_OUT_EN
        chk("p1_cos1", 16'(s1.cos_out), 16'h1ff);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
